// File: rtl/fetch_unit.sv
// fetch_unit: single-stage instruction fetch with a one-entry ir slot,
// branch redirect/flush, halt/resume control and a saturating fetch counter.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | fetching: load ir from rom_data whenever the slot is free
// S_HALT  | stopped: pc and fetch_count hold, a pending ir may still drain
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [7:0]       pc,
  input  logic [15:0]      rom_data,
  output logic [15:0]      ir,
  output logic [7:0]       ir_pc,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             br_taken,
  input  logic [7:0]       br_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  logic   slot_free;
  logic   handshake;
  logic   do_fetch;

  // Next-state and fetch decision; a redirect always suppresses the fetch.
  always_comb begin
    state_next = state;
    do_fetch   = 1'b0;
    slot_free  = !ir_valid || ir_ready;
    handshake  = ir_valid && ir_ready;
    case (state)
      S_FETCH: begin
        do_fetch = slot_free && !br_taken;
        if (halt_req) state_next = S_HALT;
      end
      S_HALT: begin
        if (resume) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // State register; halted mirrors the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == S_HALT);
    end
  end

  // Program counter: redirect wins, otherwise advance (mod 256) on a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (br_taken) begin
      pc <= br_target;
    end else if (do_fetch) begin
      pc <= pc + 8'd1;
    end
  end

  // Instruction register and its source address, loaded only on a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= 16'h0000;
      ir_pc <= 8'h00;
    end else if (do_fetch) begin
      ir    <= rom_data;
      ir_pc <= pc;
    end
  end

  // Slot occupancy: flush on redirect, fill on fetch, drain on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_valid <= 1'b0;
    end else if (br_taken) begin
      ir_valid <= 1'b0;
    end else if (do_fetch) begin
      ir_valid <= 1'b1;
    end else if (handshake) begin
      ir_valid <= 1'b0;
    end
  end

  // Fetch counter, sticks at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (do_fetch && (fetch_count != '1)) begin
      fetch_count <= fetch_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with literal expectations plus
// a cycle-level reference model compared on every falling edge.
module tb_fetch_unit;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    pc;
  logic [15:0]   rom_data;
  logic [15:0]   ir;
  logic [7:0]    ir_pc;
  logic          ir_valid;
  logic          ir_ready = 1'b1;
  logic          br_taken = 1'b0;
  logic [7:0]    br_target = 8'h00;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [15:0] rom [256];

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0]    m_pc = 8'h00;
  logic [15:0]   m_ir = 16'h0000;
  logic [7:0]    m_irpc = 8'h00;
  logic          m_valid = 1'b0;
  logic          m_halt = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  fetch_unit #(.RESET_PC(8'h00), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .rom_data(rom_data), .ir(ir),
    .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req),
    .resume(resume), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[pc];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rules applied at each edge from pre-edge values.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 8'h00; m_ir = 16'h0000; m_irpc = 8'h00;
      m_valid = 1'b0; m_halt = 1'b0; m_cnt = '0;
    end else if (!m_halt) begin
      if (br_taken) begin
        m_pc = br_target;
        m_valid = 1'b0;
      end else if (!m_valid || ir_ready) begin
        m_ir = rom[m_pc];
        m_irpc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 8'd1;
        if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
      end
      if (halt_req) m_halt = 1'b1;
    end else begin
      if (br_taken) begin
        m_pc = br_target;
        m_valid = 1'b0;
      end else if (m_valid && ir_ready) begin
        m_valid = 1'b0;
      end
      if (resume) m_halt = 1'b0;
    end
  end

  // Compare DUT against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("ir_valid", 32'(ir_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halt));
      check("fetch_count", 32'(fetch_count), 32'(m_cnt));
      if (m_valid) begin
        check("ir", 32'(ir), 32'(m_ir));
        check("ir_pc", 32'(ir_pc), 32'(m_irpc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 16'h0137 + 16'h1234);
    rom[0] = 16'h4000;
    rom[1] = 16'h0901;
    rom[5] = 16'h5005;
    rom[6] = 16'h6006;
    rom[8'h1C] = 16'hBEEF;

    // reset state
    #12;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_cnt", 32'(fetch_count), 32'h0);
    rst_n = 1'b1;

    // streaming
    step(1);
    check("s1_ir", 32'(ir), 32'h4000);
    check("s1_irpc", 32'(ir_pc), 32'h00);
    step(1);
    check("s2_ir", 32'(ir), 32'h0901);
    check("s2_irpc", 32'(ir_pc), 32'h01);
    check("s2_pc", 32'(pc), 32'h02);
    check("s2_cnt", 32'(fetch_count), 32'h2);

    // stall after first fetch
    do_reset();
    ir_ready = 1'b0;
    step(1);
    check("st_ir0", 32'(ir), 32'h4000);
    step(3);
    check("st_ir", 32'(ir), 32'h4000);
    check("st_pc", 32'(pc), 32'h01);
    check("st_cnt", 32'(fetch_count), 32'h1);
    ir_ready = 1'b1;
    step(1);
    check("st_rel_ir", 32'(ir), 32'h0901);
    check("st_rel_pc", 32'(pc), 32'h02);

    // wrap
    br_taken = 1'b1; br_target = 8'hFE;
    step(1);
    check("wr_pc", 32'(pc), 32'hFE);
    check("wr_flush", 32'(ir_valid), 32'h0);
    br_taken = 1'b0;
    step(1);
    check("wr_irpc0", 32'(ir_pc), 32'hFE);
    step(1);
    check("wr_irpc1", 32'(ir_pc), 32'hFF);
    step(1);
    check("wr_irpc2", 32'(ir_pc), 32'h00);
    check("wr_pc_end", 32'(pc), 32'h01);

    // redirect during stall
    ir_ready = 1'b0;
    step(1);
    br_taken = 1'b1; br_target = 8'h1C;
    step(1);
    check("rd_valid", 32'(ir_valid), 32'h0);
    check("rd_pc", 32'(pc), 32'h1C);
    br_taken = 1'b0; ir_ready = 1'b1;
    step(1);
    check("rd_ir", 32'(ir), 32'hBEEF);
    check("rd_irpc", 32'(ir_pc), 32'h1C);

    // halt / resume
    br_taken = 1'b1; br_target = 8'h05;
    step(1);
    br_taken = 1'b0; halt_req = 1'b1; ir_ready = 1'b0;
    step(1);
    check("h_halted", 32'(halted), 32'h1);
    check("h_pc", 32'(pc), 32'h06);
    check("h_ir", 32'(ir), 32'h5005);
    step(2);
    check("h_pc_hold", 32'(pc), 32'h06);
    check("h_valid_hold", 32'(ir_valid), 32'h1);
    ir_ready = 1'b1;
    step(1);
    check("h_drain", 32'(ir_valid), 32'h0);
    resume = 1'b1;
    step(1);
    check("h_resumed", 32'(halted), 32'h0);
    check("h_res_pc", 32'(pc), 32'h06);
    check("h_res_valid", 32'(ir_valid), 32'h0);
    resume = 1'b0; halt_req = 1'b0;
    step(1);
    check("h_fetch6", 32'(ir), 32'h6006);
    check("h_pc7", 32'(pc), 32'h07);

    // resume ignored in FETCH; redirect in HALT; redirect+halt together
    resume = 1'b1;
    step(1);
    check("res_ign", 32'(halted), 32'h0);
    resume = 1'b0; halt_req = 1'b1;
    step(1);
    halt_req = 1'b0; br_taken = 1'b1; br_target = 8'h40;
    step(1);
    check("brh_pc", 32'(pc), 32'h40);
    check("brh_halted", 32'(halted), 32'h1);
    br_taken = 1'b0; resume = 1'b1;
    step(1);
    resume = 1'b0; br_taken = 1'b1; br_target = 8'h80; halt_req = 1'b1;
    step(1);
    check("brhr_pc", 32'(pc), 32'h80);
    check("brhr_halted", 32'(halted), 32'h1);
    br_taken = 1'b0; halt_req = 1'b0; resume = 1'b1;
    step(1);
    resume = 1'b0;

    // counter saturation
    do_reset();
    step(14);
    check("sat14", 32'(fetch_count), 32'hE);
    step(6);
    check("sat20", 32'(fetch_count), 32'hF);
    check("sat_pc", 32'(pc), 32'h14);

    // async reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_pc", 32'(pc), 32'h00);
    check("ar_ir", 32'(ir), 32'h0000);
    check("ar_irpc", 32'(ir_pc), 32'h00);
    check("ar_valid", 32'(ir_valid), 32'h0);
    check("ar_halted", 32'(halted), 32'h0);
    check("ar_cnt", 32'(fetch_count), 32'h0);
    rst_n = 1'b1;
    step(1);
    check("ar_ir0", 32'(ir), 32'h4000);
    check("ar_pc1", 32'(pc), 32'h01);

    // mixed traffic, checked by the model
    for (int k = 0; k < 300; k++) begin
      ir_ready  = ($urandom_range(0, 3) != 0);
      br_taken  = ($urandom_range(0, 15) == 0);
      br_target = 8'($urandom);
      halt_req  = ($urandom_range(0, 9) == 0);
      resume    = !br_taken && ($urandom_range(0, 3) == 0);
      step(1);
    end
    br_taken = 1'b0; halt_req = 1'b0; resume = 1'b0; ir_ready = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
